// File: rtl/grf_pkg.sv
// Shared definitions for the scoreboarded general register file:
// address-width helper, pending-counter ceiling and the write-back trace format.
package grf_pkg;

  // Returns the number of address bits needed to select one of v registers.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Returns the largest value a pending counter of width w can hold.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  // Write-back trace line: PC, destination register, written value.
  localparam string GRF_TRACE_FMT = "@%08h: $%02d <= %08h";

endpackage

// File: rtl/grf_pend_ctr.sv
// One saturating pending-write counter. Increments on an accepted issue,
// decrements on a write-back; both together leave it unchanged. It never
// wraps in either direction, and a write-back against an empty counter is
// reported through underflow_o.
module grf_pend_ctr
  import grf_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [PEND_W-1:0] cnt_o,
  output logic              at_max_o,
  output logic              nonzero_o,
  output logic              underflow_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(cnt_max(PEND_W));

  logic [PEND_W-1:0] cnt_q;
  logic [PEND_W-1:0] cnt_d;

  // Next count: +1 / -1 only when the other strobe is absent and there is room.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign at_max_o    = (cnt_q == CNT_MAX);
  assign nonzero_o   = (cnt_q != '0);
  assign underflow_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/grf_scoreboard.sv
// Decode-stage register file: NUM_RD combinational read ports with
// same-cycle write forwarding, one write port, and a pending-write counter
// per register so the hazard unit can stall on in-flight results.
// Optional: define GRF_TRACE_EN to print one trace line per write-back.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  parameter int NUM_RD  = 2,
  parameter int PEND_W  = 2,
  parameter int ADDR_W  = clog2(REG_NUM)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [31:0]              wr_pc,
  output logic                     err
);

  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic [PEND_W-1:0] cnt    [REG_NUM];
  logic [REG_NUM-1:0] inc, dec, at_max, nonzero, underflow;
  logic err_q, err_d;
  logic wr_live;

  // Writes and issues aimed at register 0 are ignored everywhere.
  assign wr_live   = wr_en && (wr_addr != '0);
  assign iss_ready = (iss_addr == '0) || !at_max[iss_addr];

  for (genvar r = 0; r < REG_NUM; r++) begin : g_ctr
    assign inc[r] = iss_en && iss_ready && (iss_addr == ADDR_W'(r)) && (r != 0);
    assign dec[r] = wr_live && (wr_addr == ADDR_W'(r));

    grf_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
      .clk        (clk),
      .reset      (reset),
      .inc_i      (inc[r]),
      .dec_i      (dec[r]),
      .cnt_o      (cnt[r]),
      .at_max_o   (at_max[r]),
      .nonzero_o  (nonzero[r]),
      .underflow_o(underflow[r])
    );
  end

  // Data array: cleared on reset, register 0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < REG_NUM; r++) regs_q[r] <= '0;
    end else if (wr_live) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read ports: the write presented this cycle overrides the array, and the
  // last outstanding write to a register clears its busy flag immediately.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              hit;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a   = rd_addr[i*ADDR_W +: ADDR_W];
      hit = wr_live && (wr_addr == a);
      if (a == '0) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
      end else if (hit) begin
        rd_data[i*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = regs_q[a];
      end
      rd_busy[i] = nonzero[a] && !(hit && (cnt[a] == PEND_W'(1)));
    end
  end

  // Sticky error: any write-back that found no pending reservation.
  assign err_d = err_q | (|underflow);

  // Error flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

`ifdef GRF_TRACE_EN
  // Simulation trace of every write-back, including those to register 0.
  always @(posedge clk) begin
    if (wr_en && !reset) begin
      $display(GRF_TRACE_FMT, wr_pc, wr_addr, wr_data);
    end
  end
`else
  logic unused_wr_pc;
  assign unused_wr_pc = ^wr_pc;
`endif

endmodule
